// File: rtl/uart_rx_checker_buffered.sv
// UART receive checker: 2-FF synchroniser, frame decoder FSM with parity,
// stop-bit and break handling, and a circular FWFT buffer of decoded frames.
module uart_rx_checker_buffered #(
  parameter int G_CLOCK_FREQUENCY   = 50000000,
  parameter int G_BAUDRATE          = 115200,
  parameter int G_DATA_WIDTH        = 8,
  parameter int G_PARITY            = 0,
  parameter int G_STOP_BIT_NUMBER   = 1,
  parameter int G_FIRST_BIT         = 0,
  parameter int G_BUFFER_ADDR_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_rx,
  input  logic                           i_rd_en,
  input  logic                           i_clr_overflow,
  output logic [G_DATA_WIDTH-1:0]        o_rd_data,
  output logic                           o_rd_parity_err,
  output logic                           o_rd_frame_err,
  output logic                           o_empty,
  output logic                           o_full,
  output logic [G_BUFFER_ADDR_WIDTH:0]   o_count,
  output logic                           o_overflow,
  output logic                           o_frame_valid,
  output logic                           o_rx_busy
);

  localparam int C_BIT = G_CLOCK_FREQUENCY / G_BAUDRATE;
  localparam int CW    = $clog2(C_BIT);
  localparam int AW    = G_BUFFER_ADDR_WIDTH;
  localparam int DEPTH = 2 ** AW;
  localparam int W     = G_DATA_WIDTH;
  localparam int EW    = W + 2;

  localparam logic [CW-1:0] C_HALF    = CW'(C_BIT / 2 - 1);
  localparam logic [CW-1:0] C_FULL    = CW'(C_BIT - 1);
  localparam logic [3:0]    C_LAST_D  = 4'(W - 1);
  localparam logic [3:0]    C_LAST_S  = 4'(G_STOP_BIT_NUMBER - 1);
  localparam logic [AW:0]   C_DEPTH   = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BREAK
  } state_t;

  logic          rx_meta, rx_s;
  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [3:0]    bit_reg, bit_next;
  logic [W-1:0]  data_reg, data_next;
  logic          perr_reg, perr_next;
  logic          ferr_reg, ferr_next;
  logic          tick, commit, commit_ferr, stop_ferr;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_reg;
  logic          overflow_reg, frame_valid_reg;
  logic          do_write, do_pop, buf_empty, buf_full;
  logic [EW-1:0] head;

  // Bring the asynchronous line into the clock domain; idle level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // Decoder state, bit timer and frame accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      data_reg  <= '0;
      perr_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      data_reg  <= data_next;
      perr_reg  <= perr_next;
      ferr_reg  <= ferr_next;
    end
  end

  // Next-state logic: sample each bit at timer expiry, commit on last stop.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    bit_next    = bit_reg;
    data_next   = data_reg;
    perr_next   = perr_reg;
    ferr_next   = ferr_reg;
    commit      = 1'b0;
    tick        = (cnt_reg == '0);
    stop_ferr   = ferr_reg | ~rx_s;
    commit_ferr = stop_ferr;
    if (!tick) cnt_next = cnt_reg - 1'b1;
    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_next   = C_HALF;
        end
      end
      START: begin
        if (tick) begin
          if (rx_s) begin
            state_next = IDLE;
          end else begin
            state_next = DATA;
            cnt_next   = C_FULL;
            bit_next   = '0;
            perr_next  = 1'b0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          cnt_next = C_FULL;
          if (G_FIRST_BIT == 0) data_next = {rx_s, data_reg[W-1:1]};
          else                  data_next = {data_reg[W-2:0], rx_s};
          if (bit_reg == C_LAST_D) begin
            bit_next   = '0;
            ferr_next  = 1'b0;
            state_next = (G_PARITY != 0) ? PARITY : STOP;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          cnt_next   = C_FULL;
          state_next = STOP;
          if (G_PARITY == 1) perr_next = ^{data_reg, rx_s};
          else               perr_next = ~(^{data_reg, rx_s});
        end
      end
      STOP: begin
        if (tick) begin
          cnt_next  = C_FULL;
          ferr_next = stop_ferr;
          if (bit_reg == C_LAST_S) begin
            commit     = 1'b1;
            bit_next   = '0;
            // A low line at the final stop sample is necessarily a frame error.
            state_next = rx_s ? IDLE : BREAK;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign buf_empty = (count_reg == '0);
  assign buf_full  = (count_reg == C_DEPTH);
  assign do_pop    = i_rd_en & ~buf_empty;
  assign do_write  = commit & (~buf_full | i_rd_en);

  // Frame storage; no reset so it maps onto RAM, reads are gated by o_empty.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= {commit_ferr, perr_reg, data_reg};
  end

  // Pointers, occupancy, sticky overflow and frame-complete pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count_reg       <= '0;
      overflow_reg    <= 1'b0;
      frame_valid_reg <= 1'b0;
    end else begin
      frame_valid_reg <= commit;
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({do_write, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (commit && !do_write) overflow_reg <= 1'b1;
      else if (i_clr_overflow) overflow_reg <= 1'b0;
    end
  end

  assign head            = mem[rd_ptr];
  assign o_rd_data       = buf_empty ? '0 : head[W-1:0];
  assign o_rd_parity_err = buf_empty ? 1'b0 : head[W];
  assign o_rd_frame_err  = buf_empty ? 1'b0 : head[W+1];
  assign o_empty         = buf_empty;
  assign o_full          = buf_full;
  assign o_count         = count_reg;
  assign o_overflow      = overflow_reg;
  assign o_frame_valid   = frame_valid_reg;
  assign o_rx_busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_checker_buffered.sv
// Directed bench: dut_a is 8N1 LSB-first with a 4-entry buffer,
// dut_b is 8 bits, even parity, MSB-first, 2 stop bits.
module tb_uart_rx_checker_buffered;

  localparam int C_BIT = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1;
  logic rd_a = 1'b0, rd_b = 1'b0;
  logic clr_a = 1'b0, clr_b = 1'b0;

  logic [7:0] data_a, data_b;
  logic       perr_a, perr_b, ferr_a, ferr_b;
  logic       empty_a, empty_b, full_a, full_b;
  logic [2:0] count_a, count_b;
  logic       ovf_a, ovf_b, fv_a, fv_b, busy_a, busy_b;

  int tests = 0;
  int failed = 0;
  int fv_cnt_a = 0;
  int fv_cnt_b = 0;

  always #5 clk = ~clk;

  uart_rx_checker_buffered #(
    .G_CLOCK_FREQUENCY(1000000), .G_BAUDRATE(100000), .G_DATA_WIDTH(8),
    .G_PARITY(0), .G_STOP_BIT_NUMBER(1), .G_FIRST_BIT(0), .G_BUFFER_ADDR_WIDTH(2)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .i_rx(rx_a), .i_rd_en(rd_a), .i_clr_overflow(clr_a),
    .o_rd_data(data_a), .o_rd_parity_err(perr_a), .o_rd_frame_err(ferr_a),
    .o_empty(empty_a), .o_full(full_a), .o_count(count_a), .o_overflow(ovf_a),
    .o_frame_valid(fv_a), .o_rx_busy(busy_a)
  );

  uart_rx_checker_buffered #(
    .G_CLOCK_FREQUENCY(1000000), .G_BAUDRATE(100000), .G_DATA_WIDTH(8),
    .G_PARITY(1), .G_STOP_BIT_NUMBER(2), .G_FIRST_BIT(1), .G_BUFFER_ADDR_WIDTH(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .i_rx(rx_b), .i_rd_en(rd_b), .i_clr_overflow(clr_b),
    .o_rd_data(data_b), .o_rd_parity_err(perr_b), .o_rd_frame_err(ferr_b),
    .o_empty(empty_b), .o_full(full_b), .o_count(count_b), .o_overflow(ovf_b),
    .o_frame_valid(fv_b), .o_rx_busy(busy_b)
  );

  // Count frame-complete pulses away from the active edge.
  always @(negedge clk) begin
    if (fv_a) fv_cnt_a++;
    if (fv_b) fv_cnt_b++;
  end

  typedef struct {
    int         dut;
    logic [7:0] tx;
    logic       par;
    logic [7:0] exp_data;
    logic       exp_perr;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic line(input int dut, input logic v, input int cycles);
    if (dut == 0) rx_a = v; else rx_b = v;
    repeat (cycles) @(negedge clk);
  endtask

  // One frame in the selected DUT's format, then 'idle' cycles of high line.
  task automatic send(input int dut, input logic [7:0] d, input logic par,
                      input logic stopv, input int idle);
    line(dut, 1'b0, C_BIT);
    for (int i = 0; i < 8; i++)
      line(dut, (dut == 0) ? d[i] : d[7-i], C_BIT);
    if (dut == 1) line(dut, par, C_BIT);
    line(dut, stopv, (dut == 0) ? C_BIT : 2 * C_BIT);
    if (idle > 0) line(dut, 1'b1, idle);
  endtask

  task automatic pop_a;
    rd_a = 1'b1;
    @(negedge clk);
    rd_a = 1'b0;
  endtask

  initial begin
    int fv0;
    logic [7:0] exp_q [4];

    vecs[0] = '{0, 8'hA5, 1'b0, 8'hA5, 1'b0};
    vecs[1] = '{0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{0, 8'hFF, 1'b0, 8'hFF, 1'b0};
    vecs[3] = '{0, 8'h5A, 1'b0, 8'h5A, 1'b0};
    vecs[4] = '{0, 8'h3C, 1'b0, 8'h3C, 1'b0};
    vecs[5] = '{1, 8'h03, 1'b1, 8'h03, 1'b1};
    vecs[6] = '{1, 8'h03, 1'b0, 8'h03, 1'b0};
    vecs[7] = '{1, 8'hA5, 1'b0, 8'hA5, 1'b0};
    vecs[8] = '{1, 8'hA5, 1'b1, 8'hA5, 1'b1};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_empty", empty_a, 1);
    check("rst_full", full_a, 0);
    check("rst_count", count_a, 0);
    check("rst_ovf", ovf_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_data", data_a, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Table-driven clean and parity frames
    foreach (vecs[k]) begin
      fv0 = (vecs[k].dut == 0) ? fv_cnt_a : fv_cnt_b;
      send(vecs[k].dut, vecs[k].tx, vecs[k].par, 1'b1, C_BIT);
      $display("[TB] vec %0d dut%0d tx=0x%02h par=%0b", k, vecs[k].dut, vecs[k].tx, vecs[k].par);
      if (vecs[k].dut == 0) begin
        check("vec_fv", fv_cnt_a - fv0, 1);
        check("vec_count", count_a, 1);
        check("vec_data", data_a, vecs[k].exp_data);
        check("vec_perr", perr_a, vecs[k].exp_perr);
        check("vec_ferr", ferr_a, 0);
        pop_a;
        check("vec_empty", empty_a, 1);
      end else begin
        check("vec_fv", fv_cnt_b - fv0, 1);
        check("vec_count", count_b, 1);
        check("vec_data", data_b, vecs[k].exp_data);
        check("vec_perr", perr_b, vecs[k].exp_perr);
        check("vec_ferr", ferr_b, 0);
        rd_b = 1'b1;
        @(negedge clk);
        rd_b = 1'b0;
        check("vec_empty", empty_b, 1);
      end
    end

    // Break: stop bit low, line held low for 30 bit times in total
    fv0 = fv_cnt_a;
    send(0, 8'h00, 1'b1, 1'b0, 0);
    line(0, 1'b0, 20 * C_BIT);
    $display("[TB] break frame, line still low");
    check("brk_fv", fv_cnt_a - fv0, 1);
    check("brk_count", count_a, 1);
    check("brk_busy", busy_a, 1);
    check("brk_data", data_a, 8'h00);
    check("brk_ferr", ferr_a, 1);
    check("brk_perr", perr_a, 0);
    line(0, 1'b1, 5);
    check("brk_idle", busy_a, 0);
    check("brk_nodup", count_a, 1);
    pop_a;
    send(0, 8'h5A, 1'b1, 1'b1, C_BIT);
    $display("[TB] post-break frame 0x5A");
    check("pbrk_data", data_a, 8'h5A);
    check("pbrk_ferr", ferr_a, 0);
    pop_a;

    // Glitch: 3 cycles low must not start a frame
    fv0 = fv_cnt_a;
    line(0, 1'b0, 3);
    line(0, 1'b1, C_BIT / 2 + 1);
    $display("[TB] 3-cycle glitch");
    check("glitch_busy", busy_a, 0);
    check("glitch_count", count_a, 0);
    check("glitch_fv", fv_cnt_a - fv0, 0);

    // Overflow: five frames into a four-entry buffer
    fv0 = fv_cnt_a;
    for (int i = 1; i <= 5; i++) begin
      send(0, 8'(i * 8'h11), 1'b1, 1'b1, C_BIT);
      $display("[TB] fill frame 0x%02h", 8'(i * 8'h11));
    end
    check("ovf_fv", fv_cnt_a - fv0, 5);
    check("ovf_full", full_a, 1);
    check("ovf_count", count_a, 4);
    check("ovf_flag", ovf_a, 1);
    for (int i = 1; i <= 4; i++) begin
      check("ovf_pop", data_a, 8'(i * 8'h11));
      pop_a;
    end
    check("ovf_empty", empty_a, 1);
    check("ovf_sticky", ovf_a, 1);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    check("ovf_clr", ovf_a, 0);

    // Pop exactly on the commit cycle while full: no overflow
    for (int i = 1; i <= 4; i++) send(0, 8'(i * 8'h11), 1'b1, 1'b1, C_BIT);
    check("rw_full", full_a, 1);
    fv0 = fv_cnt_a;
    fork
      send(0, 8'h99, 1'b1, 1'b1, C_BIT);
      begin
        repeat (97) @(negedge clk);
        rd_a = 1'b1;
        @(negedge clk);
        rd_a = 1'b0;
      end
    join
    $display("[TB] frame 0x99 with pop on commit cycle");
    check("rw_fv", fv_cnt_a - fv0, 1);
    check("rw_ovf", ovf_a, 0);
    check("rw_count", count_a, 4);
    exp_q = '{8'h22, 8'h33, 8'h44, 8'h99};
    for (int i = 0; i < 4; i++) begin
      check("rw_pop", data_a, exp_q[i]);
      pop_a;
    end

    // Reset mid-DATA with two entries buffered
    send(0, 8'h12, 1'b1, 1'b1, C_BIT);
    send(0, 8'h34, 1'b1, 1'b1, C_BIT);
    check("mid_count", count_a, 2);
    line(0, 1'b0, C_BIT);
    line(0, 1'b1, 3 * C_BIT);
    check("mid_busy", busy_a, 1);
    #2 rst_n = 1'b0;
    #1;
    $display("[TB] reset asserted mid-frame");
    check("mid_rst_empty", empty_a, 1);
    check("mid_rst_count", count_a, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_data", data_a, 0);
    check("mid_rst_fv", fv_a, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    line(0, 1'b1, 2 * C_BIT);
    send(0, 8'h7E, 1'b1, 1'b1, C_BIT);
    $display("[TB] post-reset frame 0x7E");
    check("prst_count", count_a, 1);
    check("prst_data", data_a, 8'h7E);
    check("prst_err", {perr_a, ferr_a}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/uart_rx_checker_buffered.md
Name: uart_rx_checker_buffered

Overview:
Parametrised UART receive checker for the generic testbench library and synthesizable debug use. It samples one serial line and decodes frames with configurable data width, parity, stop bits and bit order. Each frame, with its error flags, goes into a circular buffer that a sequencer or host drains through a first-word-fall-through read port. Successor to the fixed-format UART checker: adds parity/frame checking, break handling, overflow tracking and parametrised depth.

Parameters:
G_CLOCK_FREQUENCY, 50000000, clk frequency in Hz.
G_BAUDRATE, 115200, line rate; bit period C_BIT = G_CLOCK_FREQUENCY/G_BAUDRATE cycles (integer divide, must be >= 4).
G_DATA_WIDTH, 8, data bits per frame, 5..9.
G_PARITY, 0, 0 = none, 1 = even, 2 = odd.
G_STOP_BIT_NUMBER, 1, stop bits, 1 or 2.
G_FIRST_BIT, 0, 0 = LSB first, 1 = MSB first.
G_BUFFER_ADDR_WIDTH, 4, buffer depth = 2**G_BUFFER_ADDR_WIDTH entries.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_rx  in  1  serial line (asynchronous, idle high)
i_rd_en  in  1  pop head entry; ignored when o_empty=1
i_clr_overflow  in  1  clears o_overflow
o_rd_data  out  G_DATA_WIDTH  head entry data (valid while o_empty=0)
o_rd_parity_err  out  1  head entry parity error
o_rd_frame_err  out  1  head entry stop-bit error
o_empty  out  1  buffer empty
o_full  out  1  buffer full
o_count  out  G_BUFFER_ADDR_WIDTH+1  entries stored
o_overflow  out  1  sticky: a frame was dropped because the buffer was full
o_frame_valid  out  1  one-cycle pulse when a frame completes (written or dropped)
o_rx_busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, pointers=0, o_count=0, o_empty=1, o_full=0, o_overflow=0, o_frame_valid=0, o_rx_busy=0, o_rd_data/err=0. The synchroniser resets to 1. Reset mid-frame discards the partial frame and all buffered entries.
- i_rx passes through a 2-FF synchroniser (reset value 1). All decoding uses the synchronised value rx_s.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: on rx_s=0, go to START and load bit counter with C_BIT/2-1.
- START: at counter expiry, sample rx_s. If 1, false start: return to IDLE with no entry. If 0, go to DATA with counter C_BIT-1.
- DATA: sample at each expiry and shift into the data register per G_FIRST_BIT. After G_DATA_WIDTH samples go to PARITY if G_PARITY!=0, else STOP.
- PARITY: sample the bit. parity_err=1 if XOR(data, bit) is not 0 for even, or not 1 for odd. parity_err=0 when G_PARITY=0.
- STOP: sample G_STOP_BIT_NUMBER bits at C_BIT spacing. frame_err=1 if any stop sample is 0.
- Frame commit on the cycle of the last stop sample:
  - o_frame_valid pulses on the next cycle.
  - Write {frame_err, parity_err, data} if not full, or if full and i_rd_en=1 on that cycle (simultaneous read+write keeps count unchanged).
  - Otherwise drop the frame and set o_overflow.
- After commit: go to IDLE if rx_s=1. If rx_s=0 and frame_err=1, go to BREAK, which stays until rx_s=1 and then enters IDLE. BREAK never creates entries.
- Buffer: circular, write/read pointers of G_BUFFER_ADDR_WIDTH bits wrap naturally.
  - o_rd_* reflect the head combinationally from the registered memory/pointer (FWFT).
  - Pop takes effect at the clock edge.
  - o_count, o_empty and o_full update the cycle after a write/pop.
  - Pop on empty is a no-op.
- o_overflow: a set has priority over i_clr_overflow in the same cycle.
- Latency: o_frame_valid rises 1 cycle after the final stop-bit sample point, about 2 + C_BIT*(0.5 + 1 + G_DATA_WIDTH + parity + stop - 1) cycles after the i_rx falling edge.

Test Plan:
- 1 MHz/100 kbaud (C_BIT=10), 8N1 LSB-first, send 0xA5 -> one o_frame_valid pulse; o_empty=0, o_count=1, o_rd_data=0xA5, both errs 0; i_rd_en -> o_empty=1.
- G_PARITY=1, send 0x03 with parity bit 1 -> entry data 0x03, parity_err=1; repeat with parity 0 -> parity_err=0. G_FIRST_BIT=1 with serial 1,0,1,0,0,1,0,1 -> data 0xA5.
- Stop bit driven 0 and line held low 30 bit times -> exactly one entry with frame_err=1, data 0x00; o_rx_busy stays 1 until the line returns high; a following 0x5A is received cleanly.
- i_rx low 3 cycles (glitch) -> no o_frame_valid, o_count=0, o_rx_busy returns to 0 within C_BIT/2+3 cycles.
- G_BUFFER_ADDR_WIDTH=2, send 0x11,0x22,0x33,0x44,0x55 without reads -> o_full=1, o_count=4, o_overflow=1, pops return 0x11..0x44. i_clr_overflow clears the flag. Pop at the commit cycle while full -> no overflow.
- Assert rst_n=0 mid-DATA with 2 entries buffered -> all outputs at reset values immediately; after release, the next clean frame 0x7E is received correctly.
